// File: rtl/div_sequencer_pkg.sv
// Shared constants and state encoding for the signed restoring divider control path.
package div_sequencer_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_SIGN = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration step counter: synchronous clear wins over enable, flags the last step.
module div_iter_counter
    import div_sequencer_pkg::*;
(
    input  logic clock,
    input  logic clear_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/div_sequencer.sv
// Control FSM for the 32-bit signed restoring divider: load, 32 shift/subtract
// steps, sign fix, then a one-cycle result strobe. Outputs decode registered state.
module div_sequencer
    import div_sequencer_pkg::*;
(
    input  logic clock,
    input  logic clear_n,
    input  logic ctrl_DIV,
    input  logic dividend_sign,
    input  logic divisor_sign,
    input  logic divisor_zero,
    input  logic trial_sign,
    output logic reg_load,
    output logic reg_shift_en,
    output logic sel_diff,
    output logic new_lsb,
    output logic neg_quot,
    output logic neg_rem,
    output logic busy,
    output logic data_resultRDY,
    output logic data_exception
);

    div_state_e state_q;
    div_state_e state_d;

    logic dvd_sign_q;
    logic dvs_sign_q;
    logic zero_q;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_last;

    div_iter_counter u_iter_counter (
        .clock   (clock),
        .clear_n (clear_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .last_o  (cnt_last)
    );

    // A start strobe is honoured in every state, so the flags re-latch on any ctrl_DIV.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            dvd_sign_q <= 1'b0;
            dvs_sign_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (ctrl_DIV) begin
            dvd_sign_q <= dividend_sign;
            dvs_sign_q <= divisor_sign;
            zero_q     <= divisor_zero;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_LOAD:  state_d = zero_q ? S_DONE : S_ITER;
            S_ITER:  state_d = cnt_last ? S_SIGN : S_ITER;
            S_SIGN:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Restart aborts whatever is in flight; the aborted op never strobes.
        if (ctrl_DIV) begin
            state_d = S_LOAD;
        end
    end

    always_comb begin
        reg_load       = 1'b0;
        reg_shift_en   = 1'b0;
        sel_diff       = 1'b0;
        new_lsb        = 1'b0;
        neg_quot       = 1'b0;
        neg_rem        = 1'b0;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        case (state_q)
            S_LOAD: begin
                reg_load     = 1'b1;
                reg_shift_en = 1'b1;
                busy         = 1'b1;
                cnt_clr      = 1'b1;
            end
            S_ITER: begin
                reg_shift_en = 1'b1;
                sel_diff     = ~trial_sign;
                new_lsb      = ~trial_sign;
                busy         = 1'b1;
                cnt_en       = 1'b1;
            end
            S_SIGN: begin
                reg_shift_en = 1'b1;
                neg_quot     = dvd_sign_q ^ dvs_sign_q;
                neg_rem      = dvd_sign_q;
                busy         = 1'b1;
            end
            S_DONE: begin
                data_resultRDY = 1'b1;
                data_exception = zero_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Sequencer plus behavioural shift register/subtractor; results scoreboarded against a vector table.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        ctrl_DIV;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        trial_sign;
    logic        reg_load, reg_shift_en, sel_diff, new_lsb;
    logic        neg_quot, neg_rem, busy, data_resultRDY, data_exception;

    always #5 clock = ~clock;

    div_sequencer dut (
        .clock          (clock),
        .clear_n        (clear_n),
        .ctrl_DIV       (ctrl_DIV),
        .dividend_sign  (dividend[31]),
        .divisor_sign   (divisor[31]),
        .divisor_zero   (divisor == 32'd0),
        .trial_sign     (trial_sign),
        .reg_load       (reg_load),
        .reg_shift_en   (reg_shift_en),
        .sel_diff       (sel_diff),
        .new_lsb        (new_lsb),
        .neg_quot       (neg_quot),
        .neg_rem        (neg_rem),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    function automatic logic [31:0] mag(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    // Behavioural datapath: {remainder,quotient} register; the 33rd write after a load is the sign fix.
    logic [63:0] sreg;
    logic [31:0] dvd_abs_q, dvs_abs_q;
    logic [5:0]  steps;
    logic [63:0] shifted;
    logic [32:0] diff;

    assign shifted    = sreg << 1;
    assign diff       = {1'b0, shifted[63:32]} - {1'b0, dvs_abs_q};
    assign trial_sign = diff[32];

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sreg      <= '0;
            steps     <= '0;
            dvd_abs_q <= '0;
            dvs_abs_q <= '0;
        end else begin
            if (ctrl_DIV) begin
                dvd_abs_q <= mag(dividend);
                dvs_abs_q <= mag(divisor);
            end
            if (reg_load) begin
                sreg  <= {32'd0, dvd_abs_q};
                steps <= '0;
            end else if (reg_shift_en) begin
                if (steps == 6'd32) begin
                    sreg[63:32] <= neg_rem  ? (~sreg[63:32] + 32'd1) : sreg[63:32];
                    sreg[31:0]  <= neg_quot ? (~sreg[31:0] + 32'd1)  : sreg[31:0];
                end else begin
                    sreg <= {sel_diff ? diff[31:0] : shifted[63:32], shifted[31:1], new_lsb};
                end
                steps <= steps + 6'd1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        logic        nq;
        logic        nr;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        logic        nq;
        logic        nr;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;
    logic seen_nq  = 1'b0;
    logic seen_nr  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outputs"}, {23'd0, reg_load, reg_shift_en, sel_diff, new_lsb, neg_quot,
                                neg_rem, busy, data_resultRDY, data_exception}, 32'd0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_strobe"}, data_resultRDY, 0);
    endtask

    task automatic monitor();
        exp_t e;
        if (busy) busy_cyc++;
        if (neg_quot) seen_nq = 1'b1;
        if (neg_rem) seen_nr = 1'b1;
        if (data_resultRDY) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("exception", data_exception, e.exc);
                chk("busy_cycles", busy_cyc, e.exc ? 1 : 34);
                chk("neg_quot_seen", seen_nq, e.nq);
                chk("neg_rem_seen", seen_nr, e.nr);
                if (!e.exc) begin
                    chk("quotient", sreg[31:0], e.q);
                    chk("remainder", sreg[63:32], e.r);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        monitor();
    endtask

    // Called just after a negedge: drive a start, push its expectation, run one cycle.
    task automatic start_op(input vec_t v);
        exp_t e;
        dividend = v.a;
        divisor  = v.b;
        ctrl_DIV = 1'b1;
        e.cyc = cyc + 1 + (v.exc ? 1 : 34);
        e.q   = v.q;
        e.r   = v.r;
        e.exc = v.exc;
        e.nq  = v.nq;
        e.nr  = v.nr;
        sb.push_back(e);
        busy_cyc = 0;
        seen_nq  = 1'b0;
        seen_nr  = 1'b0;
        step();
        ctrl_DIV = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int start;
        start = done_cnt;
        for (int i = 0; i < max && done_cnt == start; i++) step();
        chk({name, "_strobe_count"}, done_cnt - start, 1);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                                input logic [31:0] r, input logic exc, input logic nq, input logic nr);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.exc = exc; v.nq = nq; v.nr = nr;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish by time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int saved;
        vecs[0] = mk(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 1'b0);
        vecs[1] = mk(-32'sd100,      32'd7,          -32'sd14,       -32'sd2,        1'b0, 1'b1, 1'b1);
        vecs[2] = mk(32'd100,        -32'sd7,        -32'sd14,       32'd2,          1'b0, 1'b1, 1'b0);
        vecs[3] = mk(32'd5,          32'd0,          32'd0,          32'd0,          1'b1, 1'b0, 1'b0);
        vecs[4] = mk(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b0, 1'b1);
        vecs[5] = mk(32'd0,          32'd9,          32'd0,          32'd0,          1'b0, 1'b0, 1'b0);
        vecs[6] = mk(-32'sd7,        -32'sd2,        32'd3,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1);
        vecs[7] = mk(32'd7,          32'd2,          32'd3,          32'd1,          1'b0, 1'b0, 1'b0);

        clear_n  = 1'b0;
        ctrl_DIV = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i]);
            wait_done($sformatf("vec%0d", i), 45);
            step();
            chk_all_zero($sformatf("vec%0d_idle", i));
        end

        // Restart at count 10 with 9/3: only the second op strobes.
        start_op(vecs[0]);
        repeat (11) step();
        void'(sb.pop_back());
        start_op(mk(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0));
        wait_done("restart", 45);
        saved = done_cnt;
        repeat (5) step();
        chk("restart_single_strobe", done_cnt, saved);

        // Half-cycle reset at count 20 kills the op outright.
        start_op(vecs[0]);
        repeat (21) step();
        clear_n = 1'b0;
        #2;
        chk_all_zero("midop_reset");
        sb.delete();
        #2;
        clear_n = 1'b1;
        saved = done_cnt;
        repeat (40) step();
        chk("no_strobe_after_reset", done_cnt, saved);
        start_op(vecs[7]);
        wait_done("post_reset", 45);
        step();

        // Start issued during the DONE cycle: that strobe already fired, the new op proceeds.
        start_op(mk(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0));
        wait_done("back2back_a", 45);
        start_op(vecs[1]);
        wait_done("back2back_b", 45);
        step();
        chk("queue_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
